// File: rtl/polyline_raster_pkg.sv
// Shared types and step helpers for the polyline rasteriser.
// Coordinates are unsigned CW bits; Bresenham error terms are signed CW+2 bits.
package raster_pkg;
    localparam int CW = 10;
    localparam int SW = 4;

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;
    typedef logic [CW-1:0]        coord_t;
    typedef logic signed [CW+1:0] err_t;
    typedef logic signed [CW+2:0] e2_t;

    function automatic err_t abs_diff(input coord_t a, input coord_t b);
        return (a >= b) ? err_t'({2'b00, a - b}) : err_t'({2'b00, b - a});
    endfunction

    function automatic err_t sign(input coord_t from, input coord_t to);
        return (to >= from) ? err_t'(1) : err_t'(-1);
    endfunction
endpackage

// File: rtl/polyline_raster_if.sv
// Segment-in and pixel-out valid/ready channels of the rasteriser.
// slave is the rasteriser's view, master is the driver/sink view.
interface polyline_raster_if;
    import raster_pkg::*;

    logic             seg_valid;
    logic             seg_ready;
    logic             seg_cont;
    coord_t           seg_x0;
    coord_t           seg_y0;
    coord_t           seg_x1;
    coord_t           seg_y1;
    logic [SW-1:0]    spacing;
    logic             pt_valid;
    logic             pt_ready;
    coord_t           pt_x;
    coord_t           pt_y;
    logic             pt_last;

    modport master (
        output seg_valid, seg_cont, seg_x0, seg_y0, seg_x1, seg_y1, spacing, pt_ready,
        input  seg_ready, pt_valid, pt_x, pt_y, pt_last
    );

    modport slave (
        input  seg_valid, seg_cont, seg_x0, seg_y0, seg_x1, seg_y1, spacing, pt_ready,
        output seg_ready, pt_valid, pt_x, pt_y, pt_last
    );
endinterface

// File: rtl/polyline_raster_bresenham_step.sv
// Bresenham walker: holds the current pixel and error term, steps once per advance.
// load has priority over advance; at_end flags the current pixel as the segment endpoint.
module bresenham_step
    import raster_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   advance,
    input  coord_t ld_x,
    input  coord_t ld_y,
    input  err_t   ld_err,
    input  err_t   dx,
    input  err_t   dy,
    input  err_t   sx,
    input  err_t   sy,
    input  coord_t end_x,
    input  coord_t end_y,
    output coord_t x,
    output coord_t y,
    output logic   at_end
);
    coord_t x_q, x_d, y_q, y_d;
    err_t   err_q, err_d;
    e2_t    e2;
    logic   step_x, step_y;

    always_comb begin
        e2     = e2_t'({err_q, 1'b0});
        step_x = (e2 >= e2_t'(dy));
        step_y = (e2 <= e2_t'(dx));
        x_d    = x_q;
        y_d    = y_q;
        err_d  = err_q;
        if (load) begin
            x_d   = ld_x;
            y_d   = ld_y;
            err_d = ld_err;
        end else if (advance) begin
            x_d   = step_x ? x_q + coord_t'(sx) : x_q;
            y_d   = step_y ? y_q + coord_t'(sy) : y_q;
            err_d = err_q + (step_x ? dy : err_t'(0)) + (step_y ? dx : err_t'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            err_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            err_q <= err_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign at_end = (x_q == end_x) && (y_q == end_y);
endmodule

// File: rtl/polyline_raster.sv
// Bresenham polyline rasteriser with point spacing and segment chaining; one walked pixel per cycle.
// Emitted pixels stall the walk until pt_ready; optional clipping under RASTER_CLIP_EN.
module polyline_raster
    import raster_pkg::*;
#(
    parameter int X_MAX = 799,
    parameter int Y_MAX = 599
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    polyline_raster_if.slave    bus,
    output logic                seg_done,
    output logic                busy
);
`ifdef RASTER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    localparam coord_t XLIM = coord_t'(X_MAX);
    localparam coord_t YLIM = coord_t'(Y_MAX);

    state_t        state_q, state_d;
    coord_t        sx0_q, sx0_d, sy0_q, sy0_d, ex_q, ex_d, ey_q, ey_d;
    coord_t        rec_x_q, rec_x_d, rec_y_q, rec_y_d;
    coord_t        pt_x_q, pt_x_d, pt_y_q, pt_y_d;
    logic [SW-1:0] spc_q, spc_d, cnt_q, cnt_d;
    logic          skip_q, skip_d, rec_vld_q, rec_vld_d;
    logic          pt_valid_q, pt_valid_d, pt_last_q, pt_last_d, seg_done_q, seg_done_d;
    logic          accept, adv, emit, clipped, at_end;
    coord_t        cur_x, cur_y;
    err_t          dx, dy, sx, sy;

    assign bus.seg_ready = (state_q == IDLE) & ~frame_start;
    assign accept        = bus.seg_valid & bus.seg_ready;

    assign dx = abs_diff(sx0_q, ex_q);
    assign dy = -abs_diff(sy0_q, ey_q);
    assign sx = sign(sx0_q, ex_q);
    assign sy = sign(sy0_q, ey_q);

    bresenham_step u_step (
        .clk, .rst,
        .load   (state_q == SETUP && !frame_start),
        .advance(adv),
        .ld_x   (sx0_q), .ld_y(sy0_q), .ld_err(dx + dy),
        .dx, .dy, .sx, .sy,
        .end_x  (ex_q), .end_y(ey_q),
        .x      (cur_x), .y(cur_y), .at_end
    );

    assign clipped = CLIP_EN && ((cur_x > XLIM) || (cur_y > YLIM));

    always_comb begin
        state_d = state_q;   sx0_d = sx0_q;       sy0_d = sy0_q;
        ex_d = ex_q;         ey_d = ey_q;         spc_d = spc_q;
        cnt_d = cnt_q;       skip_d = skip_q;     rec_vld_d = rec_vld_q;
        rec_x_d = rec_x_q;   rec_y_d = rec_y_q;   pt_x_d = pt_x_q;
        pt_y_d = pt_y_q;     pt_valid_d = pt_valid_q;
        pt_last_d = pt_last_q;
        seg_done_d = 1'b0;
        adv  = 1'b0;
        emit = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                // A continued segment starts at the stored endpoint and must not redraw it
                skip_d  = bus.seg_cont & rec_vld_q;
                sx0_d   = skip_d ? rec_x_q : bus.seg_x0;
                sy0_d   = skip_d ? rec_y_q : bus.seg_y0;
                ex_d    = bus.seg_x1;
                ey_d    = bus.seg_y1;
                spc_d   = bus.spacing;
                state_d = SETUP;
            end
            SETUP: begin
                cnt_d = '0;
                if (skip_q && sx0_q == ex_q && sy0_q == ey_q) begin
                    state_d    = IDLE;
                    seg_done_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pt_valid_q && !bus.pt_ready) begin
                    state_d = RUN;
                end else if (pt_valid_q && pt_last_q) begin
                    pt_valid_d = 1'b0;
                    pt_last_d  = 1'b0;
                    state_d    = IDLE;
                    seg_done_d = 1'b1;
                end else begin
                    emit       = (cnt_q == '0 || at_end) && !skip_q && !clipped;
                    pt_valid_d = emit;
                    pt_last_d  = emit & at_end;
                    if (emit) begin
                        pt_x_d = cur_x;
                        pt_y_d = cur_y;
                    end
                    skip_d = 1'b0;
                    cnt_d  = (cnt_q == spc_q) ? '0 : cnt_q + 1'b1;
                    if (at_end) begin
                        rec_x_d   = cur_x;
                        rec_y_d   = cur_y;
                        rec_vld_d = 1'b1;
                        if (!emit) begin
                            state_d    = IDLE;
                            seg_done_d = 1'b1;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (frame_start) begin
            state_d    = IDLE;
            pt_valid_d = 1'b0;
            pt_last_d  = 1'b0;
            seg_done_d = 1'b0;
            rec_vld_d  = 1'b0;
            skip_d     = 1'b0;
            adv        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;  sx0_q <= '0;  sy0_q <= '0;  ex_q <= '0;  ey_q <= '0;
            spc_q <= '0;  cnt_q <= '0;  skip_q <= 1'b0;  rec_vld_q <= 1'b0;
            rec_x_q <= '0;  rec_y_q <= '0;  pt_x_q <= '0;  pt_y_q <= '0;
            pt_valid_q <= 1'b0;  pt_last_q <= 1'b0;  seg_done_q <= 1'b0;
        end else begin
            state_q <= state_d;  sx0_q <= sx0_d;  sy0_q <= sy0_d;  ex_q <= ex_d;  ey_q <= ey_d;
            spc_q <= spc_d;  cnt_q <= cnt_d;  skip_q <= skip_d;  rec_vld_q <= rec_vld_d;
            rec_x_q <= rec_x_d;  rec_y_q <= rec_y_d;  pt_x_q <= pt_x_d;  pt_y_q <= pt_y_d;
            pt_valid_q <= pt_valid_d;  pt_last_q <= pt_last_d;  seg_done_q <= seg_done_d;
        end
    end

    assign bus.pt_valid = pt_valid_q;
    assign bus.pt_x     = pt_x_q;
    assign bus.pt_y     = pt_y_q;
    assign bus.pt_last  = pt_last_q;
    assign seg_done     = seg_done_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_polyline_raster.sv
// Randomised and directed checks of polyline_raster against an integer Bresenham reference.
module tb_polyline_raster;
    import raster_pkg::*;

    localparam int XM = 799;
    localparam int YM = 599;
`ifdef RASTER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct { int x; int y; bit last; } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_start = 1'b0;
    logic seg_done, busy;

    polyline_raster_if bus();

    polyline_raster #(.X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .bus(bus.slave), .seg_done(seg_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    pix_t exp_q[$];
    bit   rec_v = 1'b0;
    int   rec_x = 0;
    int   rec_y = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk index i, emit on spacing phase or endpoint, minus skipped start and clipped pixels
    function automatic void build(input int x0, input int y0, input int x1, input int y1,
                                  input int sp, input bit skip);
        int x = x0;
        int y = y0;
        int dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        int dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
        int sx = (x1 >= x0) ? 1 : -1;
        int sy = (y1 >= y0) ? 1 : -1;
        int err = dx + dy;
        int e2;
        int i = 0;
        bit at_end, em;
        exp_q.delete();
        forever begin
            at_end = (x == x1) && (y == y1);
            em = ((i % (sp + 1)) == 0 || at_end) && !(skip && i == 0)
                 && !(CLIP && (x > XM || y > YM));
            if (em) exp_q.push_back('{x, y, at_end});
            if (at_end) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            i++;
        end
    endfunction

    task automatic run_seg(input bit cont, input int x0, input int y0, input int x1, input int y1,
                           input int sp, input int rdy_pct, input int abort_at);
        bit     skip = cont && rec_v;
        int     hs = 0;
        bit     held = 1'b0, prev_last = 1'b0, done = 1'b0;
        coord_t hx = '0, hy = '0;
        logic   hl = 1'b0;
        pix_t   e;
        build(skip ? rec_x : x0, skip ? rec_y : y0, x1, y1, sp, skip);
        bus.seg_valid = 1'b1;
        bus.seg_cont  = cont;
        bus.seg_x0    = coord_t'(x0);
        bus.seg_y0    = coord_t'(y0);
        bus.seg_x1    = coord_t'(x1);
        bus.seg_y1    = coord_t'(y1);
        bus.spacing   = SW'(sp);
        #1;
        check("seg_ready", bus.seg_ready, 1);
        @(negedge clk);
        bus.seg_valid = 1'b0;
        check("setup_pt_valid", bus.pt_valid, 0);
        check("setup_busy", busy, 1);
        bus.pt_ready = ($urandom_range(99) < rdy_pct);
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            if (held) begin
                check("hold_valid", bus.pt_valid, 1);
                check("hold_x", bus.pt_x, hx);
                check("hold_y", bus.pt_y, hy);
                check("hold_last", bus.pt_last, hl);
            end
            if (prev_last) begin
                check("done_after_last", seg_done, 1);
                check("idle_after_last", busy, 0);
                done = 1'b1;
            end else if (seg_done) begin
                check("pixels_left", exp_q.size(), 0);
                check("idle_at_done", busy, 0);
                done = 1'b1;
            end else if (hs == abort_at) begin
                frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
                check("abort_pt_valid", bus.pt_valid, 0);
                check("abort_seg_done", seg_done, 0);
                check("abort_busy", busy, 0);
                @(negedge clk);
                check("abort_no_done", seg_done, 0);
                rec_v = 1'b0;
                return;
            end else begin
                bus.pt_ready = ($urandom_range(99) < rdy_pct);
                if (bus.pt_valid && bus.pt_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_pixel", bus.pt_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pt_x", bus.pt_x, e.x);
                        check("pt_y", bus.pt_y, e.y);
                        check("pt_last", bus.pt_last, e.last);
                    end
                    hs++;
                    prev_last = bus.pt_last;
                end
                held = bus.pt_valid && !bus.pt_ready;
                hx = bus.pt_x;
                hy = bus.pt_y;
                hl = bus.pt_last;
            end
        end
        if (!done) check("timeout", 0, 1);
        else begin
            rec_v = 1'b1;
            rec_x = x1;
            rec_y = y1;
        end
    endtask

    initial begin
        bus.seg_valid = 1'b0;
        bus.seg_cont  = 1'b0;
        bus.seg_x0    = '0;
        bus.seg_y0    = '0;
        bus.seg_x1    = '0;
        bus.seg_y1    = '0;
        bus.spacing   = '0;
        bus.pt_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pt_valid", bus.pt_valid, 0);
        check("rst_pt_last", bus.pt_last, 0);
        check("rst_pt_x", bus.pt_x, 0);
        check("rst_pt_y", bus.pt_y, 0);
        check("rst_seg_done", seg_done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_seg_ready", bus.seg_ready, 1);

        // cont without a record behaves as a plain segment
        run_seg(1, 0, 0, 5, 2, 0, 100, -1);
        run_seg(0, 10, 10, 10, 20, 3, 100, -1);
        run_seg(0, 0, 0, 4, 0, 0, 100, -1);
        run_seg(1, 9, 9, 4, 4, 0, 100, -1);
        run_seg(0, 0, 0, 5, 2, 0, 50, -1);
        run_seg(0, 0, 0, 5, 2, 0, 100, 3);
        run_seg(1, 20, 20, 23, 25, 0, 100, -1);
        run_seg(0, 7, 7, 7, 7, 0, 70, -1);
        run_seg(1, 3, 3, 7, 7, 2, 70, -1);
        run_seg(0, 795, 0, 805, 0, 0, 100, -1);
        run_seg(0, 30, 30, 10, 10, 1, 80, -1);

        @(negedge clk);
        frame_start = 1'b1;
        bus.seg_valid = 1'b1;
        #1;
        check("frame_start_blocks", bus.seg_ready, 0);
        @(negedge clk);
        frame_start = 1'b0;
        bus.seg_valid = 1'b0;
        check("frame_start_no_accept", busy, 0);
        rec_v = 1'b0;

        for (int n = 0; n < 40; n++) begin
            int a = $urandom_range(1023);
            int b = $urandom_range(1023);
            int c = a + int'($urandom_range(60)) - 30;
            int d = b + int'($urandom_range(60)) - 30;
            if (c < 0) c = 0;
            if (c > 1023) c = 1023;
            if (d < 0) d = 0;
            if (d > 1023) d = 1023;
            run_seg($urandom_range(9) < 3, a, b, c, d, $urandom_range(15),
                    ($urandom_range(1) == 1) ? 100 : 60,
                    ($urandom_range(9) == 0) ? int'($urandom_range(3)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
